// File: rtl/multi_pulse_synchro.sv
// Multi-channel level synchroniser with optional stability filter, edge detection
// and a per-channel pulse stretcher that flags events dropped mid-pulse.
module multi_pulse_synchro #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int FILTER      = 0,
  parameter int PULSE_WIDTH = 1
) (
  input  logic                aclk,
  input  logic                arstn,
  input  logic [CHANNELS-1:0] data_i,
  input  logic [CHANNELS-1:0] clear_i,
  output logic [CHANNELS-1:0] data_o,
  output logic [CHANNELS-1:0] busy_o,
  output logic [CHANNELS-1:0] overflow_o
);

  localparam logic [7:0] PW_LOAD = 8'(PULSE_WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   synced_s;
    logic                   filt_s;
    logic                   prev_r;
    logic                   edge_s;
    logic                   evt_r;
    state_t                 state_r;
    logic [7:0]             rem_r;
    logic                   pulse_r;
    logic                   ovf_r;

    // Plain flop chain, no logic between stages.
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        sync_r <= '0;
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], data_i[ch]};
      end
    end

    assign synced_s = sync_r[SYNC_STAGES-1];

    if (FILTER == 0) begin : g_nofilt
      assign filt_s = synced_s;
    end else begin : g_filt
      localparam logic [7:0] STAB_LAST = 8'(FILTER - 1);
      logic       filt_r;
      logic [7:0] stab_r;

      // Accept a new level only after it has differed for FILTER consecutive cycles.
      always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
          filt_r <= 1'b0;
          stab_r <= 8'd0;
        end else if (synced_s == filt_r) begin
          stab_r <= 8'd0;
        end else if (stab_r == STAB_LAST) begin
          filt_r <= synced_s;
          stab_r <= 8'd0;
        end else begin
          stab_r <= stab_r + 8'd1;
        end
      end

      assign filt_s = filt_r;
    end

    // Edge select on the filtered level.
    always_comb begin
      edge_s = 1'b0;
      case (MODE)
        0:       edge_s = filt_s & ~prev_r;
        1:       edge_s = ~filt_s & prev_r;
        default: edge_s = filt_s ^ prev_r;
      endcase
    end

    // Registered event keeps the rise at SYNC_STAGES+FILTER+1 edges.
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        prev_r <= 1'b0;
        evt_r  <= 1'b0;
      end else begin
        prev_r <= filt_s;
        evt_r  <= edge_s;
      end
    end

    // Pulse generator; a drop sets the sticky flag and beats a same-cycle clear.
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
        state_r <= IDLE;
        rem_r   <= 8'd0;
        pulse_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else begin
        ovf_r <= ovf_r & ~clear_i[ch];
        case (state_r)
          IDLE: begin
            if (evt_r) begin
              state_r <= PULSE;
              rem_r   <= PW_LOAD;
              pulse_r <= 1'b1;
            end else begin
              pulse_r <= 1'b0;
            end
          end
          PULSE: begin
            if (rem_r == 8'd1) begin
              if (evt_r) begin
                rem_r   <= PW_LOAD;
                pulse_r <= 1'b1;
              end else begin
                state_r <= IDLE;
                rem_r   <= 8'd0;
                pulse_r <= 1'b0;
              end
            end else begin
              rem_r   <= rem_r - 8'd1;
              pulse_r <= 1'b1;
              if (evt_r) begin
                ovf_r <= 1'b1;
              end else begin
                ovf_r <= ovf_r & ~clear_i[ch];
              end
            end
          end
          default: begin
            state_r <= IDLE;
            rem_r   <= 8'd0;
            pulse_r <= 1'b0;
          end
        endcase
      end
    end

    assign data_o[ch]     = pulse_r;
    assign busy_o[ch]     = pulse_r;
    assign overflow_o[ch] = ovf_r;
  end

endmodule

// File: tb/tb_multi_pulse_synchro.sv
// Directed bench for multi_pulse_synchro: four parameterisations share clock and reset;
// per-cycle expectations are queued up front and compared as the cycles elapse.
module tb_multi_pulse_synchro;

  logic       aclk = 1'b0;
  logic       arstn;
  logic [3:0] clr;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] o0_d, o0_b, o0_o;
  logic [3:0] o1_d, o1_b, o1_o;
  logic [3:0] o2_d, o2_b, o2_o;
  logic [3:0] o3_d, o3_b, o3_o;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] ov;
  } exp_t;
  exp_t q[$];

  logic [3:0] obs_d, obs_b, obs_o;

  always #5 aclk = ~aclk;

  multi_pulse_synchro u_def (
    .aclk(aclk), .arstn(arstn), .data_i(d0), .clear_i(clr),
    .data_o(o0_d), .busy_o(o0_b), .overflow_o(o0_o)
  );
  multi_pulse_synchro #(.MODE(2), .PULSE_WIDTH(4)) u_pw4 (
    .aclk(aclk), .arstn(arstn), .data_i(d1), .clear_i(clr),
    .data_o(o1_d), .busy_o(o1_b), .overflow_o(o1_o)
  );
  multi_pulse_synchro #(.MODE(2), .PULSE_WIDTH(8)) u_pw8 (
    .aclk(aclk), .arstn(arstn), .data_i(d2), .clear_i(clr),
    .data_o(o2_d), .busy_o(o2_b), .overflow_o(o2_o)
  );
  multi_pulse_synchro #(.FILTER(3)) u_flt (
    .aclk(aclk), .arstn(arstn), .data_i(d3), .clear_i(clr),
    .data_o(o3_d), .busy_o(o3_b), .overflow_o(o3_o)
  );

  always_comb begin
    obs_d = o0_d;
    obs_b = o0_b;
    obs_o = o0_o;
    case (sel)
      1:       begin obs_d = o1_d; obs_b = o1_b; obs_o = o1_o; end
      2:       begin obs_d = o2_d; obs_b = o2_b; obs_o = o2_o; end
      3:       begin obs_d = o3_d; obs_b = o3_b; obs_o = o3_o; end
      default: begin obs_d = o0_d; obs_b = o0_b; obs_o = o0_o; end
    endcase
  end

  task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_n(input logic [3:0] d, input logic [3:0] ov, input int n);
    exp_t e;
    e.d  = d;
    e.ov = ov;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic check_q(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s expectation queue empty at cycle %0d", tag, i);
      end else begin
        e = q.pop_front();
        cmp({tag, "_data"}, obs_d, e.d);
        cmp({tag, "_busy"}, obs_b, e.d);
        cmp({tag, "_ovf"},  obs_o, e.ov);
      end
    end
  endtask

  initial begin
    arstn = 1'b0;
    clr   = 4'b0000;
    d0    = 4'b0000;
    d1    = 4'b0000;
    d2    = 4'b0000;
    d3    = 4'b0000;
    #12;
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      cmp("rst_data", obs_d, 4'b0000);
      cmp("rst_busy", obs_b, 4'b0000);
      cmp("rst_ovf",  obs_o, 4'b0000);
    end
    @(posedge aclk);
    #1;
    arstn = 1'b1;

    // idle after reset
    sel = 0;
    push_n(4'b0000, 4'b0000, 20);
    check_q("idle", 20);

    // defaults: single 1-cycle pulse, 3 edges after sampling edge, fall ignored
    d0 = 4'b0001;
    push_n(4'b0000, 4'b0000, 3);
    push_n(4'b0001, 4'b0000, 1);
    push_n(4'b0000, 4'b0000, 8);
    check_q("def_pulse", 12);
    d0 = 4'b0000;
    push_n(4'b0000, 4'b0000, 8);
    check_q("def_fall", 8);

    // both edges, 4-cycle pulses
    sel = 1;
    d1 = 4'b0010;
    push_n(4'b0000, 4'b0000, 3);
    push_n(4'b0010, 4'b0000, 4);
    push_n(4'b0000, 4'b0000, 3);
    check_q("pw4_rise", 10);
    d1 = 4'b0000;
    push_n(4'b0000, 4'b0000, 3);
    push_n(4'b0010, 4'b0000, 4);
    push_n(4'b0000, 4'b0000, 5);
    check_q("pw4_fall", 12);

    // second edge mid-pulse is dropped and flagged; clear removes the flag
    sel = 2;
    d2 = 4'b0100;
    push_n(4'b0000, 4'b0000, 3);
    push_n(4'b0100, 4'b0000, 1);
    check_q("pw8_start", 4);
    d2 = 4'b0000;
    push_n(4'b0100, 4'b0000, 3);
    push_n(4'b0100, 4'b0100, 4);
    push_n(4'b0000, 4'b0100, 3);
    check_q("pw8_drop", 10);
    clr = 4'b0100;
    push_n(4'b0000, 4'b0000, 1);
    check_q("pw8_clear", 1);
    clr = 4'b0000;
    push_n(4'b0000, 4'b0000, 3);
    check_q("pw8_after", 3);

    // filter: 2-cycle glitch rejected, 5-cycle level accepted at latency 6
    sel = 3;
    d3 = 4'b1000;
    push_n(4'b0000, 4'b0000, 2);
    check_q("flt_glitch", 2);
    d3 = 4'b0000;
    push_n(4'b0000, 4'b0000, 10);
    check_q("flt_quiet", 10);
    d3 = 4'b1000;
    push_n(4'b0000, 4'b0000, 5);
    check_q("flt_hold", 5);
    d3 = 4'b0000;
    push_n(4'b0000, 4'b0000, 1);
    push_n(4'b1000, 4'b0000, 1);
    push_n(4'b0000, 4'b0000, 8);
    check_q("flt_pulse", 10);

    // reset on the 2nd cycle of an 8-cycle pulse
    sel = 2;
    d2 = 4'b0100;
    push_n(4'b0000, 4'b0000, 3);
    push_n(4'b0100, 4'b0000, 2);
    check_q("mid_rst_pre", 5);
    arstn = 1'b0;
    d2    = 4'b0000;
    #1;
    cmp("mid_rst_data", obs_d, 4'b0000);
    cmp("mid_rst_busy", obs_b, 4'b0000);
    cmp("mid_rst_ovf",  obs_o, 4'b0000);
    @(posedge aclk);
    @(posedge aclk);
    #1;
    arstn = 1'b1;
    push_n(4'b0000, 4'b0000, 15);
    check_q("mid_rst_post", 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
